// File: rtl/spmv_seq_pkg.sv
// Shared state encoding and default sizing for the SpMV sequence controller.
package spmv_seq_pkg;

    typedef enum logic [2:0] {
        RST_ST,
        START,
        LOAD,
        WAIT,
        OUT,
        DONE
    } state_t;

    localparam int DEF_LOAD_LEN  = 64;
    localparam int DEF_WAIT_LEN  = 16;
    localparam int DEF_OUT_LEN   = 2048;
    localparam int DEF_PRE_LEAD  = 2;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_IN_ADDR_W = 8;
    localparam int DEF_ADDR_W    = 11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spmv_seq_cnt.sv
// Clearable, enabled up-counter that saturates at MAX and flags it with tc.
module spmv_seq_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spmv_seq_ctrl.sv
// Pass sequencer for the sparse MxV datapath: input load, pipeline fill, output drain.
// Optional output back-pressure is enabled by defining SPMV_SEQ_STALL_EN.
module spmv_seq_ctrl
    import spmv_seq_pkg::*;
#(
    parameter int LOAD_LEN  = DEF_LOAD_LEN,
    parameter int WAIT_LEN  = DEF_WAIT_LEN,
    parameter int OUT_LEN   = DEF_OUT_LEN,
    parameter int PRE_LEAD  = DEF_PRE_LEAD,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int IN_ADDR_W = DEF_IN_ADDR_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idle,
    input  logic [3:0]           num_pass,
    input  logic                 out_ready,
    output logic                 eninput,
    output logic                 weainput,
    output logic [IN_ADDR_W-1:0] input_addr,
    output logic [NUM_CH-1:0]    ena,
    output logic [NUM_CH-1:0]    wea,
    output logic [ADDR_W-1:0]    addra,
    output logic                 dateout,
    output logic                 spv_driver_C_bram,
    output logic [3:0]           pass_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int PH_MAX = max2(LOAD_LEN, WAIT_LEN) - 1;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BT_W   = $clog2(OUT_LEN);

    localparam logic [PH_W-1:0]   LOAD_LAST = PH_W'(LOAD_LEN - 1);
    localparam logic [PH_W-1:0]   WAIT_LAST = PH_W'(WAIT_LEN - 1);
    localparam logic [PH_W-1:0]   SPV_ON    = PH_W'(WAIT_LEN - PRE_LEAD - 1);
    localparam logic [BT_W-1:0]   SPV_OFF   = BT_W'(OUT_LEN - PRE_LEAD - 1);
    localparam logic [ADDR_W-1:0] AD_PRE    = ADDR_W'(OUT_LEN - 2);

    state_t            state;
    logic [3:0]        np_q;
    logic [PH_W-1:0]   ph;
    logic [BT_W-1:0]   bt;
    logic              bt_tc;
    logic              ph_tc_unused;
    logic              ad_tc_unused;
    logic              rdy;
    logic              beat;
    logic              last_beat;
    logic              ph_last;
    logic              in_phase;
    logic              ad_en;
    logic              ad_to_sat;

`ifdef SPMV_SEQ_STALL_EN
    assign rdy = out_ready;
`else
    logic rdy_unused;
    assign rdy_unused = out_ready;
    assign rdy        = 1'b1;
`endif

    assign weainput  = 1'b0;
    assign wea       = '0;

    assign in_phase  = (state == LOAD) || (state == WAIT);
    assign ph_last   = ((state == LOAD) && (ph == LOAD_LAST)) ||
                       ((state == WAIT) && (ph == WAIT_LAST));
    assign beat      = (state == OUT) && dateout && rdy;
    assign last_beat = beat && bt_tc;
    assign ad_en     = (state == WAIT) || beat;
    // addra is about to land on its last location this edge; ena drops with it
    assign ad_to_sat = ad_en && (addra == AD_PRE);

    spmv_seq_cnt #(.W(PH_W), .MAX(PH_MAX)) u_ph_cnt (
        .clk (clk),
        .rst (rst),
        .clr (idle || ph_last || !in_phase),
        .en  (in_phase),
        .cnt (ph),
        .tc  (ph_tc_unused)
    );

    spmv_seq_cnt #(.W(BT_W), .MAX(OUT_LEN - 1)) u_bt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (idle || last_beat || (state != OUT)),
        .en  (beat),
        .cnt (bt),
        .tc  (bt_tc)
    );

    spmv_seq_cnt #(.W(ADDR_W), .MAX(OUT_LEN - 1)) u_ad_cnt (
        .clk (clk),
        .rst (rst),
        .clr (idle || last_beat || !((state == WAIT) || (state == OUT))),
        .en  (ad_en),
        .cnt (addra),
        .tc  (ad_tc_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst || idle) begin
            state             <= (!rst) ? RST_ST : START;
            np_q              <= '0;
            eninput           <= 1'b0;
            input_addr        <= '0;
            ena               <= '0;
            dateout           <= 1'b0;
            spv_driver_C_bram <= 1'b0;
            pass_idx          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state)
                RST_ST: state <= RST_ST;
                START: begin
                    eninput    <= 1'b1;
                    input_addr <= '0;
                    busy       <= 1'b1;
                    if (pass_idx == 4'd0)
                        np_q <= (num_pass == 4'd0) ? 4'd1 : num_pass;
                    state <= LOAD;
                end
                LOAD: begin
                    input_addr <= input_addr + IN_ADDR_W'(1);
                    if (ph_last) begin
                        eninput    <= 1'b0;
                        input_addr <= '0;
                        ena        <= '1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (ph == SPV_ON) spv_driver_C_bram <= 1'b1;
                    if (ad_to_sat)    ena <= '0;
                    if (ph_last) begin
                        dateout <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (beat) begin
                        if (ad_to_sat)      ena <= '0;
                        if (bt == SPV_OFF)  spv_driver_C_bram <= 1'b0;
                        if (bt_tc) begin
                            dateout           <= 1'b0;
                            ena               <= '0;
                            spv_driver_C_bram <= 1'b0;
                            if (({1'b0, pass_idx} + 5'd1) < {1'b0, np_q}) begin
                                pass_idx <= pass_idx + 4'd1;
                                state    <= START;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: done <= 1'b0;
                default: state <= RST_ST;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_seq_ctrl.sv
// Scoreboard bench for spmv_seq_ctrl: a timeline model queues the expected per-cycle outputs.
module tb_spmv_seq_ctrl;

    localparam int LL = 4, WL = 3, OL = 8, PL = 2, NC = 2, IAW = 8, AW = 4;
`ifdef SPMV_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           idle = 1'b0;
    logic [3:0]     num_pass = 4'd1;
    logic           out_ready = 1'b1;
    logic           eninput, weainput, dateout, spv_driver_C_bram, busy, done;
    logic [IAW-1:0] input_addr;
    logic [NC-1:0]  ena, wea;
    logic [AW-1:0]  addra;
    logic [3:0]     pass_idx;

    spmv_seq_ctrl #(
        .LOAD_LEN(LL), .WAIT_LEN(WL), .OUT_LEN(OL), .PRE_LEAD(PL),
        .NUM_CH(NC), .IN_ADDR_W(IAW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .idle(idle), .num_pass(num_pass), .out_ready(out_ready),
        .eninput(eninput), .weainput(weainput), .input_addr(input_addr),
        .ena(ena), .wea(wea), .addra(addra), .dateout(dateout),
        .spv_driver_C_bram(spv_driver_C_bram), .pass_idx(pass_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           en_in;
        logic [IAW-1:0] iaddr;
        logic [NC-1:0]  ena;
        logic [AW-1:0]  addra;
        logic           dout;
        logic           spv;
        logic [3:0]     pidx;
        logic           busy;
        logic           done;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs, exp_s;
    int   errors = 0;
    int   checks = 0;

    function automatic smp_t mk(bit en_in, int ia, bit en_o, int ad, bit dout, bit spv,
                                int pidx, bit bsy, bit dn);
        smp_t s;
        s.en_in = en_in;
        s.iaddr = IAW'(ia);
        s.ena   = en_o ? {NC{1'b1}} : {NC{1'b0}};
        s.addra = AW'(ad);
        s.dout  = dout;
        s.spv   = spv;
        s.pidx  = 4'(pidx);
        s.busy  = bsy;
        s.done  = dn;
        return s;
    endfunction

    // Expected trace, one entry per clock starting with the edge that samples idle.
    // Edges whose index lies in [s_lo, s_hi) see out_ready low.
    task automatic build_run(input int np, input int s_lo, input int s_hi);
        int t, k, a, eff;
        eff = (np == 0) ? 1 : np;
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        t = 1;
        for (int p = 0; p < eff; p++) begin
            for (int i = 0; i < LL; i++) begin
                exp_q.push_back(mk(1, i, 0, 0, 0, 0, p, 1, 0)); t++;
            end
            for (int j = 0; j < WL; j++) begin
                exp_q.push_back(mk(0, 0, j < OL-1, j, 0, j >= WL-PL, p, 1, 0)); t++;
            end
            k = 0;
            while (k < OL) begin
                a = (WL + k < OL - 1) ? WL + k : OL - 1;
                exp_q.push_back(mk(0, 0, a < OL-1, a, 1, k < OL-PL, p, 1, 0));
                t++;
                if (!(STALL_EN && t >= s_lo && t < s_hi)) k++;
            end
            if (p < eff - 1) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, p+1, 1, 0)); t++;
            end else begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, p, 0, 1));
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, p, 0, 0));
            end
        end
    endtask

    task automatic step(input bit idle_v, input bit rdy);
        idle      = idle_v;
        out_ready = rdy;
        @(posedge clk);
        #1;
        obs = {eninput, input_addr, ena, addra, dateout, spv_driver_C_bram, pass_idx, busy, done};
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs !== '0 || weainput !== 1'b0 || wea !== '0) begin
                errors++; $display("FAIL reset_zero got=%h required=0", obs);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs !== '0) begin
                errors++; $display("FAIL rst_st_hold got=%h required=0", obs);
            end
        end
    endtask

    task automatic test_single_pass(input int np, input int want_done);
        int done_t = -1;
        num_pass = 4'(np);
        build_run(np, -1, -1);
        for (int t = 0; exp_q.size() > 0; t++) begin
            step(t == 0, 1'b1);
            exp_s = exp_q.pop_front();
            if (obs.done && done_t < 0) done_t = t;
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL pass_np%0d t=%0d got=%h required=%h", np, t, obs, exp_s);
            end
        end
        checks++;
        if (done_t != want_done) begin
            errors++; $display("FAIL done_time_np%0d got=%0d required=%0d", np, done_t, want_done);
        end
    endtask

    task automatic test_multi_pass;
        int done_t = -1;
        int n_done = 0;
        num_pass = 4'd3;
        build_run(3, -1, -1);
        for (int t = 0; exp_q.size() > 0; t++) begin
            if (t >= 2) num_pass = 4'd1;
            step(t == 0, 1'b1);
            exp_s = exp_q.pop_front();
            if (obs.done) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL multi_pass t=%0d got=%h required=%h", t, obs, exp_s);
            end
        end
        checks++;
        if (done_t != 48 || n_done != 1) begin
            errors++; $display("FAIL multi_done got_t=%0d got_n=%0d required_t=48 required_n=1", done_t, n_done);
        end
    endtask

    task automatic test_stall;
        int done_t = -1;
        int want;
        want = 16 + (STALL_EN ? 5 : 0);
        num_pass = 4'd1;
        build_run(1, 11, 16);
        for (int t = 0; exp_q.size() > 0; t++) begin
            step(t == 0, !(t >= 11 && t < 16));
            exp_s = exp_q.pop_front();
            if (obs.done && done_t < 0) done_t = t;
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL stall t=%0d got=%h required=%h", t, obs, exp_s);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (done_t != want) begin
            errors++; $display("FAIL stall_done_time got=%0d required=%0d", done_t, want);
        end
    endtask

    task automatic test_idle_abort;
        num_pass = 4'd1;
        build_run(1, -1, -1);
        for (int t = 0; t <= 10; t++) begin
            step(t == 0, 1'b1);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL abort_pre t=%0d got=%h required=%h", t, obs, exp_s);
            end
        end
        build_run(1, -1, -1);
        for (int t = 0; exp_q.size() > 0; t++) begin
            step(t == 0, 1'b1);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL abort_restart t=%0d got=%h required=%h", t, obs, exp_s);
            end
        end
    endtask

    task automatic test_rst_mid;
        num_pass = 4'd2;
        build_run(2, -1, -1);
        for (int t = 0; t <= 6; t++) begin
            step(t == 0, 1'b1);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                errors++; $display("FAIL rst_mid_pre t=%0d got=%h required=%h", t, obs, exp_s);
            end
        end
        rst = 1'b0;
        step(1'b0, 1'b1);
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL rst_mid_zero got=%h required=0", obs);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs !== '0) begin
                errors++; $display("FAIL rst_mid_hold got=%h required=0", obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass(1, 16);
        test_multi_pass();
        test_single_pass(0, 16);
        test_stall();
        test_idle_abort();
        test_rst_mid();
        test_single_pass(2, 32);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
